// File: rtl/read_slave_burst.sv
// AXI3-style read slave: AR requests queue in a small FIFO, and a burst engine
// turns each request into R beats, reading memory combinationally per beat.
module read_slave_burst #(
    parameter int buswidth = 32,
    parameter int idwidth  = 2,
    parameter int depth    = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [idwidth-1:0]  ARID,
    input  logic [buswidth-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic [1:0]          ARLOCK,
    input  logic [3:0]          ARCACHE,
    input  logic [2:0]          ARPROT,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [idwidth-1:0]  RID,
    output logic [buswidth-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [buswidth-1:0] address_out,
    output logic                memread,
    input  logic [buswidth-1:0] data_in
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);
    localparam logic [1:0] MAX_SIZE = (buswidth == 64) ? 2'd3 : 2'd2;
    localparam logic [buswidth-1:0] ONE = {{(buswidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BURST, ERRBURST} state_t;

    // Lock/cache/protection attributes carry no meaning for this slave.
    logic unused_attr;
    assign unused_attr = ^{ARLOCK, ARCACHE, ARPROT};

    // ---------------- request FIFO ----------------
    logic [idwidth-1:0]  id_mem    [depth];
    logic [buswidth-1:0] addr_mem  [depth];
    logic [3:0]          len_mem   [depth];
    logic [1:0]          size_mem  [depth];
    logic [1:0]          burst_mem [depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign ARREADY = ARESETn && !full;
    assign push    = ARVALID && ARREADY;

    always_ff @(posedge ACLK) begin
        if (push) begin
            id_mem[wr_ptr_q]    <= ARID;
            addr_mem[wr_ptr_q]  <= ARADDR;
            len_mem[wr_ptr_q]   <= ARLEN;
            size_mem[wr_ptr_q]  <= ARSIZE;
            burst_mem[wr_ptr_q] <= ARBURST;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- head decode ----------------
    logic [idwidth-1:0]  h_id;
    logic [buswidth-1:0] h_addr, h_bytes, h_wmask;
    logic [3:0]          h_len;
    logic [1:0]          h_size, h_burst;
    logic                h_len_ok, h_align_ok, h_illegal;

    assign h_id    = id_mem[rd_ptr_q];
    assign h_addr  = addr_mem[rd_ptr_q];
    assign h_len   = len_mem[rd_ptr_q];
    assign h_size  = size_mem[rd_ptr_q];
    assign h_burst = burst_mem[rd_ptr_q];
    assign h_bytes = ONE << h_size;
    // Wrap window is (len+1)*bytes; only meaningful when len+1 is a power of two.
    assign h_wmask    = ((buswidth'(h_len) + ONE) << h_size) - ONE;
    assign h_len_ok   = (h_len == 4'd1) || (h_len == 4'd3) || (h_len == 4'd7) || (h_len == 4'd15);
    assign h_align_ok = ((h_addr & (h_bytes - ONE)) == '0);
    assign h_illegal  = (h_burst == 2'b11) || (h_size > MAX_SIZE) ||
                        ((h_burst == 2'b10) && (!h_len_ok || !h_align_ok));

    // ---------------- burst engine ----------------
    state_t              state_q, state_d;
    logic [buswidth-1:0] cur_addr_q, cur_addr_d, wmask_q, wmask_d, next_addr, bytes_c, inc_addr;
    logic [3:0]          beats_q, beats_d;
    logic [idwidth-1:0]  id_q, id_d;
    logic [1:0]          size_q, size_d, burst_q, burst_d;

    assign bytes_c  = ONE << size_q;
    assign inc_addr = cur_addr_q + bytes_c;

    always_comb begin
        case (burst_q)
            2'b01:   next_addr = inc_addr;
            2'b10:   next_addr = (cur_addr_q & ~wmask_q) | (inc_addr & wmask_q);
            default: next_addr = cur_addr_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cur_addr_q <= '0;
            wmask_q    <= '0;
            beats_q    <= '0;
            id_q       <= '0;
            size_q     <= '0;
            burst_q    <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            wmask_q    <= wmask_d;
            beats_q    <= beats_d;
            id_q       <= id_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        wmask_d     = wmask_q;
        beats_d     = beats_q;
        id_d        = id_q;
        size_d      = size_q;
        burst_d     = burst_q;
        pop         = 1'b0;
        RVALID      = 1'b0;
        memread     = 1'b0;
        address_out = '0;
        RDATA       = '0;
        RRESP       = 2'b00;
        RID         = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_addr_d = h_addr;
                    wmask_d    = h_wmask;
                    beats_d    = h_len;
                    id_d       = h_id;
                    size_d     = h_size;
                    burst_d    = h_burst;
                    state_d    = h_illegal ? ERRBURST : BURST;
                end
            end
            BURST, ERRBURST: begin
                RVALID = 1'b1;
                RID    = id_q;
                if (state_q == BURST) begin
                    memread     = 1'b1;
                    address_out = cur_addr_q;
                    RDATA       = data_in;
                end else begin
                    RRESP = 2'b10;
                end
                if (RREADY) begin
                    if (beats_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d    = beats_q - 4'd1;
                        cur_addr_d = next_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign RLAST = RVALID && (beats_q == 4'd0);

endmodule

// File: tb/tb_read_slave_burst.sv
// Directed bench for read_slave_burst: a request/beat-list model predicts every
// cycle's outputs; literal address/response lists pin the model on key cases.
module tb_read_slave_burst;
    localparam int BW = 32;
    localparam int IDW = 2;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           ARESETn;
    logic [IDW-1:0] ARID;
    logic [BW-1:0]  ARADDR;
    logic [3:0]     ARLEN;
    logic [1:0]     ARSIZE, ARBURST, ARLOCK;
    logic [3:0]     ARCACHE;
    logic [2:0]     ARPROT;
    logic           ARVALID, ARREADY;
    logic [IDW-1:0] RID;
    logic [BW-1:0]  RDATA;
    logic [1:0]     RRESP;
    logic           RLAST, RVALID, RREADY;
    logic [BW-1:0]  address_out, data_in;
    logic           memread;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction
    assign data_in = mem_f(address_out);

    read_slave_burst #(.buswidth(BW), .idwidth(IDW), .depth(DEPTH)) dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .address_out(address_out), .memread(memread), .data_in(data_in)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { logic [IDW-1:0] id; logic [31:0] addr; int len; int size; int burst; } req_t;
    typedef struct { logic [31:0] addr; bit err; bit last; logic [IDW-1:0] id; } beat_t;
    req_t  reqq[$];
    beat_t cur_q[$];

    task automatic expand(input req_t r);
        logic [31:0] a, bytes, w, base;
        bit legal;
        a = r.addr;
        bytes = 32'd1 << r.size;
        w = bytes * (r.len + 1);
        legal = (r.burst != 3) && (bytes <= BW/8);
        if (r.burst == 2)
            legal = legal && (r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15) && (a % bytes == 0);
        for (int i = 0; i <= r.len; i++) begin
            beat_t b;
            b.addr = a; b.err = !legal; b.last = (i == r.len); b.id = r.id;
            cur_q.push_back(b);
            if (r.burst == 1) a = a + bytes;
            else if (r.burst == 2) begin
                base = a - (a % w);
                a = base + ((a - base + bytes) % w);
            end
        end
    endtask

    task automatic model_step();
        bit do_push;
        req_t r;
        if (!ARESETn) begin
            reqq.delete();
            cur_q.delete();
            return;
        end
        do_push = ARVALID && (reqq.size() < DEPTH);
        if (cur_q.size() > 0) begin
            if (RREADY) void'(cur_q.pop_front());
        end else if (reqq.size() > 0) begin
            r = reqq.pop_front();
            expand(r);
        end
        if (do_push) begin
            r.id = ARID; r.addr = ARADDR; r.len = int'(ARLEN); r.size = int'(ARSIZE); r.burst = int'(ARBURST);
            reqq.push_back(r);
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    logic [31:0] obs_addr[$];
    logic [1:0]  obs_resp[$];
    bit          obs_last[$];
    logic [IDW-1:0] obs_id[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("arready", ARREADY, (ARESETn && reqq.size() < DEPTH) ? 1 : 0);
            if (cur_q.size() > 0) begin
                chk("rvalid", RVALID, 1);
                chk("rlast", RLAST, cur_q[0].last);
                chk("rresp", RRESP, cur_q[0].err ? 2 : 0);
                chk("rid", RID, cur_q[0].id);
                chk("memread", memread, !cur_q[0].err);
                chk("rdata", RDATA, cur_q[0].err ? 0 : mem_f(cur_q[0].addr));
                if (!cur_q[0].err) chk("address_out", address_out, cur_q[0].addr);
            end else begin
                chk("idle_rvalid", RVALID, 0);
                chk("idle_rlast", RLAST, 0);
                chk("idle_memread", memread, 0);
                chk("idle_rdata", RDATA, 0);
                chk("idle_rresp", RRESP, 0);
                chk("idle_rid", RID, 0);
                chk("idle_addr", address_out, 0);
            end
            if (RVALID && RREADY) begin
                obs_addr.push_back(address_out);
                obs_resp.push_back(RRESP);
                obs_last.push_back(RLAST);
                obs_id.push_back(RID);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
    endtask

    task automatic set_ar(input int id, input logic [31:0] addr, input int len, input int size, input int burst);
        ARID = IDW'(id); ARADDR = addr; ARLEN = 4'(len); ARSIZE = 2'(size); ARBURST = 2'(burst);
        ARLOCK = 2'b01; ARCACHE = 4'hF; ARPROT = 3'h5; ARVALID = 1'b1;
    endtask

    task automatic send_ar(input int id, input logic [31:0] addr, input int len, input int size, input int burst);
        set_ar(id, addr, len, size, burst);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            if (cur_q.size() == 0 && reqq.size() == 0) begin done = 1; break; end
            tick();
        end
        chk({name, "_drain"}, done, 1);
    endtask

    task automatic chk_addrs(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input int n);
        logic [31:0] exp[4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        chk({name, "_beats"}, obs_addr.size(), n);
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            chk({name, "_addr"}, obs_addr[i], exp[i]);
            chk({name, "_last"}, obs_last[i], (i == n-1) ? 1 : 0);
        end
    endtask

    initial begin
        ARESETn = 1'b0; RREADY = 1'b1;
        set_ar(0, 0, 0, 0, 0); ARVALID = 1'b0;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_arready_lit", ARREADY, 0);
        chk("rst_rvalid_lit", RVALID, 0);
        ARESETn = 1'b1;
        #2 chk("post_rst_arready_lit", ARREADY, 1);

        // INCR 0x100, 4 beats
        clear_obs();
        send_ar(1, 32'h100, 3, 2, 1);
        wait_idle("incr");
        chk_addrs("incr", 32'h100, 32'h104, 32'h108, 32'h10C, 4);
        foreach (obs_resp[i]) chk("incr_resp", obs_resp[i], 0);

        // WRAP 0x38 in a 16-byte window
        clear_obs();
        send_ar(2, 32'h38, 3, 2, 2);
        wait_idle("wrap");
        chk_addrs("wrap", 32'h38, 32'h3C, 32'h30, 32'h34, 4);

        // FIXED 0x20 with a 2-cycle stall on beat 2
        clear_obs();
        send_ar(0, 32'h20, 2, 2, 0);
        tick(); tick();
        RREADY = 1'b0;
        tick(); tick();
        RREADY = 1'b1;
        wait_idle("fixed");
        chk_addrs("fixed", 32'h20, 32'h20, 32'h20, 32'h0, 3);

        // Reserved burst type: error beats
        clear_obs();
        send_ar(2, 32'h40, 1, 2, 3);
        wait_idle("rsvd");
        chk("rsvd_beats", obs_resp.size(), 2);
        foreach (obs_resp[i]) begin
            chk("rsvd_resp", obs_resp[i], 2);
            chk("rsvd_id", obs_id[i], 2);
        end

        // Other illegal forms: oversize, misaligned wrap, bad wrap length
        clear_obs();
        send_ar(3, 32'h0, 0, 3, 1);
        send_ar(1, 32'h32, 3, 2, 2);
        send_ar(0, 32'h40, 2, 2, 2);
        wait_idle("illegal");
        chk("illegal_beats", obs_resp.size(), 1 + 4 + 3);
        foreach (obs_resp[i]) chk("illegal_resp", obs_resp[i], 2);

        // INCR past the top of the address space
        clear_obs();
        send_ar(1, 32'hFFFF_FFF8, 2, 2, 1);
        wait_idle("top");
        chk_addrs("top", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 3);

        // Queue fill under back-pressure
        clear_obs();
        RREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ar(i % 4, 32'h1000 + 32'(i) * 32'h100, 1, 2, 1);
            tick();
        end
        chk("full_arready_lit", ARREADY, 0);
        set_ar(3, 32'h9000, 1, 2, 1);
        tick();
        ARVALID = 1'b0;
        tick();
        RREADY = 1'b1;
        wait_idle("fill");
        chk("fill_beats", obs_addr.size(), 10);
        for (int i = 0; i < 10 && i < obs_addr.size(); i++)
            chk("fill_order", obs_addr[i], 32'h1000 + 32'(i/2) * 32'h100 + 32'(i%2) * 4);

        // Reset mid-burst with two queued requests
        clear_obs();
        send_ar(1, 32'h200, 7, 2, 1);
        send_ar(2, 32'h300, 1, 2, 1);
        send_ar(3, 32'h400, 1, 2, 1);
        chk("midrst_beat2_lit", address_out, 32'h204);
        ARESETn = 1'b0;
        tick(); tick();
        ARESETn = 1'b1;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_rvalid_lit", RVALID, 0);
            chk("midrst_arready_lit", ARREADY, 1);
        end
        chk("midrst_no_beats", obs_addr.size(), 0);

        // Traffic resumes normally afterwards
        clear_obs();
        send_ar(0, 32'h500, 1, 2, 1);
        wait_idle("resume");
        chk_addrs("resume", 32'h500, 32'h504, 32'h0, 32'h0, 2);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/read_slave_burst.md
READ_SLAVE_BURST -- requirements
Module: read_slave_burst

Interface
REQ-001 The block SHALL have parameter buswidth, default 32, setting the ARADDR, RDATA, address_out and data_in width (legal values 32 or 64).
REQ-002 The block SHALL have parameter idwidth, default 2, setting the ARID and RID width.
REQ-003 The block SHALL have parameter depth, default 4, setting the AR request queue depth (power of 2, at least 2).
REQ-004 The block SHALL have these ports: ACLK  in  1  clock; ARESETn  in  1  reset.
REQ-005 ACLK SHALL be the only clock; ARESETn SHALL be a synchronous, active-low reset.
REQ-006 The AR channel ports SHALL be: ARID in idwidth; ARADDR in buswidth; ARLEN in 4 (beats-1); ARSIZE in 2 (bytes=1<<ARSIZE); ARBURST in 2; ARLOCK in 2; ARCACHE in 4; ARPROT in 3; ARVALID in 1; ARREADY out 1.
REQ-007 The R channel ports SHALL be: RID out idwidth; RDATA out buswidth; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-008 The memory ports SHALL be: address_out out buswidth; memread out 1; data_in in buswidth, combinationally valid in the same cycle as address_out while memread=1.

Function
REQ-009 The block SHALL store ARID, ARADDR, ARLEN, ARSIZE and ARBURST in a depth-entry FIFO; ARLOCK, ARCACHE and ARPROT SHALL be accepted and ignored.
REQ-010 ARREADY SHALL equal !full, registered-free, independent of ARVALID; a push SHALL occur iff ARVALID&&ARREADY.
REQ-011 Push and pop in the same cycle SHALL both take effect; when full, no push, including on a pop cycle (no pass-through).
REQ-012 The burst engine FSM states SHALL be IDLE, BURST and ERRBURST.
REQ-013 In IDLE with FIFO non-empty, the FSM SHALL pop the head, load cur_addr=ARADDR and beats=ARLEN, and go to BURST (legal request) or ERRBURST (illegal request) next cycle; a one-cycle IDLE bubble SHALL separate consecutive bursts.
REQ-014 Illegal conditions: ARBURST=2'b11; (1<<ARSIZE) > buswidth/8; WRAP with ARLEN not in {1,3,7,15}; WRAP with ARADDR not aligned to the size.
REQ-015 In BURST: RVALID=1, memread=1, address_out=cur_addr, RDATA=data_in, RRESP=2'b00, RID=stored ID.
REQ-016 In ERRBURST: RVALID=1, memread=0, RDATA=0, RRESP=2'b10 (SLVERR) on every beat, with the full ARLEN+1 beats still returned.
REQ-017 RLAST SHALL be 1 iff RVALID and beats==0.
REQ-018 A beat SHALL complete only on RVALID&&RREADY; while RREADY=0, all R outputs and address_out SHALL hold stable.
REQ-019 On a beat completion with beats!=0, beats SHALL decrement and cur_addr SHALL update per REQ-020..022.
REQ-020 On a beat completion with beats==0, the FSM SHALL return to IDLE.
REQ-021 FIXED (00): cur_addr SHALL be unchanged.
REQ-022 INCR (01): cur_addr+bytes, modulo 2^buswidth (wraps to 0 past the top).
REQ-023 WRAP (10): with W=(ARLEN+1)*bytes, cur_addr=(cur_addr & ~(W-1)) | ((cur_addr+bytes) & (W-1)).
REQ-024 In IDLE: RVALID=0, RLAST=0, memread=0, RDATA=0, RRESP=0, RID=0, address_out=0.

Reset
REQ-025 On a rising ACLK edge with ARESETn=0, the block SHALL empty the FIFO and force the FSM to IDLE, with all outputs at the REQ-024 values.
REQ-026 While ARESETn=0, ARREADY SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; after ARESETn rises, no beat of the abandoned burst or any queued request SHALL appear.
REQ-028 ARREADY SHALL be 1 on the first cycle after ARESETn is sampled high.

Verification
REQ-029 INCR, ARADDR=0x100, ARLEN=3, ARSIZE=2, RREADY=1 -> address_out 0x100,0x104,0x108,0x10C on consecutive cycles; RLAST on the 4th beat only; RRESP=00.
REQ-030 WRAP, ARADDR=0x38, ARLEN=3, ARSIZE=2 -> addresses 0x38,0x3C,0x30,0x34; RLAST on 0x34.
REQ-031 FIXED, ARADDR=0x20, ARLEN=2, with RREADY low for 2 cycles at beat 2 -> 3 beats all at 0x20; outputs stable while stalled.
REQ-032 ARBURST=11, ARLEN=1, ARID=2 -> 2 beats, RRESP=10, RDATA=0, memread=0, RID=2.
REQ-033 depth=4, RREADY=0, 5 ARVALID pulses -> first pops into the engine; ARREADY drops after 5 accepted (4 queued); later bursts return in order, with 1 IDLE cycle between bursts.
REQ-034 Reset during beat 2 of an ARLEN=7 INCR with 2 queued requests -> after release, RVALID stays 0 and ARREADY=1 until a new AR is accepted.
